// File: rtl/if_fetch_stage_pkg.sv
// ============================================================================
// Module   : if_fetch_stage_pkg
// Purpose  : Shared widths, constants and FSM encoding for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_stage_pkg;

    localparam int unsigned C_XLEN      = 32;
    localparam logic [31:0] C_PC_STEP   = 32'd4;
    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_stage_fifo.sv
// ============================================================================
// Module   : if_fetch_stage_fifo
// Purpose  : Synchronous FIFO with flush, registered head and next-count view.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_wr    = wr_en & ~flush;
        do_rd    = rd_en & ~flush & (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign count_nxt = count_d;

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction fetch: PC, credit-limited imem requests, redirect
//            flush with stale-response discard, buffered decode handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [C_XLEN-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [C_XLEN-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [C_XLEN-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [C_XLEN-1:0] id_instr,
    output logic [C_XLEN-1:0] id_pc,
    output logic [6:0]        id_opcode,
    output logic [2:0]        id_func3
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [C_XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [C_XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     in_flight_q, in_flight_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic              req_valid_q, req_valid_d;

    logic              req_fire, id_fire, fifo_wr;
    logic [CW:0]       credit_used;
    logic [63:0]       fifo_rd_data;
    logic [CW-1:0]     fifo_count, fifo_count_nxt;

    always_comb begin
        req_fire    = req_valid_q & imem_req_ready;
        id_fire     = (fifo_count != '0) & id_ready;
        fifo_wr     = imem_rsp_valid & (state_q == ST_RUN) & ~redirect_valid;
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        discard_d   = discard_q;
        in_flight_d = in_flight_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + C_PC_STEP;
        end

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (imem_rsp_valid) begin
                    rsp_pc_d = rsp_pc_q + C_PC_STEP;
                end
            end
            ST_FLUSH: begin
                if (imem_rsp_valid) begin
                    discard_d = discard_q - CW'(1);
                    if (discard_q == CW'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase

        // Every request still outstanding after this cycle belongs to the old stream.
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            rsp_pc_d   = word_align(redirect_pc);
            discard_d  = in_flight_d;
            state_d    = (in_flight_d != '0) ? ST_FLUSH : ST_RUN;
        end

        credit_used = {1'b0, in_flight_d} + {1'b0, fifo_count_nxt};
        req_valid_d = (state_d != ST_BOOT) & ~redirect_valid
                    & (credit_used < (CW + 1)'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            in_flight_q <= '0;
            discard_q   <= '0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
            req_valid_q <= req_valid_d;
        end
    end

    if_fetch_stage_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .wr_en     (fifo_wr),
        .wr_data   ({rsp_pc_q, imem_rsp_data}),
        .rd_en     (id_fire),
        .rd_data   (fifo_rd_data),
        .count     (fifo_count),
        .count_nxt (fifo_count_nxt)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc_q;
    assign id_valid       = (fifo_count != '0);
    assign id_pc          = fifo_rd_data[63:32];
    assign id_instr       = fifo_rd_data[31:0];
    assign id_opcode      = fifo_rd_data[6:0];
    assign id_func3       = fifo_rd_data[14:12];

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Directed + randomized bench with a latency-modelled memory and a
//            PC-stream reference model for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [2:0]  id_func3;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode),
        .id_func3       (id_func3)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        memq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          hs_count = 0;
    logic [31:0] pc_exp = 32'h0;
    logic [31:0] req_exp = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] last_acc_addr = 32'h0;
    bit          have_last_acc = 1'b0;
    bit          prev_redir = 1'b0;
    bit          prev_stall = 1'b0;
    bit          saw_wrap = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h00A2_8263;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs, serve memory, drive inputs, advance the reference.
    task automatic step(input bit redir, input logic [31:0] tgt, input int rdy_pct, input int idr_pct);
        bit          acc;
        logic [31:0] w;
        int          due;
        @(negedge clk);
        cyc++;
        if (prev_redir) begin
            chk("id_valid_after_redirect", 32'(id_valid), 32'd0);
            chk("no_req_after_redirect", 32'(imem_req_valid), 32'd0);
        end
        if (prev_stall) begin
            chk("stall_valid_held", 32'(imem_req_valid), 32'd1);
            chk("stall_addr_held", imem_req_addr, prev_addr);
        end
        if (imem_req_valid) chk("addr_align", 32'(imem_req_addr[1:0]), 32'd0);

        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end
        imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
        id_ready       = (int'($urandom_range(99)) < idr_pct);
        redirect_valid = redir;
        redirect_pc    = tgt;

        acc = imem_req_valid && imem_req_ready;
        if (acc) begin
            chk("req_addr", imem_req_addr, req_exp);
            req_exp = req_exp + 32'd4;
            if (have_last_acc && last_acc_addr == 32'hFFFF_FFFC && imem_req_addr == 32'h0)
                saw_wrap = 1'b1;
            last_acc_addr = imem_req_addr;
            have_last_acc = 1'b1;
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{addr: imem_req_addr, due: due});
            chk("credit_limit", 32'(memq.size() <= 4), 32'd1);
        end

        if (id_valid && id_ready) begin
            w = mem_word(pc_exp);
            chk("id_pc", id_pc, pc_exp);
            chk("id_instr", id_instr, w);
            chk("id_opcode", 32'(id_opcode), 32'(w[6:0]));
            chk("id_func3", 32'(id_func3), 32'(w[14:12]));
            pc_exp = pc_exp + 32'd4;
            hs_count++;
        end
        if (redir) begin
            pc_exp  = tgt & ~32'd3;
            req_exp = tgt & ~32'd3;
        end
        prev_redir = redir;
        prev_stall = imem_req_valid && !imem_req_ready && !redir;
        prev_addr  = imem_req_addr;
    endtask

    task automatic drive_idle();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_id_valid"}, 32'(id_valid), 32'd0);
        chk({tag, "_id_pc"}, id_pc, 32'd0);
        chk({tag, "_id_instr"}, id_instr, 32'd0);
        chk({tag, "_id_opcode"}, 32'(id_opcode), 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive_idle();

        // Reset held for five cycles, then release into BOOT
        repeat (5) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);

        // Latency-1 streaming at full throughput
        lat_lo = 1; lat_hi = 1;
        repeat (10) step(1'b0, 32'h0, 100, 100);
        hs_count = 0;
        repeat (20) step(1'b0, 32'h0, 100, 100);
        chk("stream_rate", 32'(hs_count), 32'd20);

        // Decode back-pressure: requests must stop at the credit limit
        repeat (10) step(1'b0, 32'h0, 100, 0);
        chk("bp_req_stopped", 32'(imem_req_valid), 32'd0);
        chk("bp_buffer_full", 32'(id_valid), 32'd1);
        hs_count = 0;
        repeat (20) step(1'b0, 32'h0, 100, 100);
        chk("bp_resume_rate", 32'(hs_count >= 15), 32'd1);

        // Redirect with exactly two requests in flight
        lat_lo = 3; lat_hi = 3;
        repeat (5) step(1'b0, 32'h0, 0, 100);
        step(1'b0, 32'h0, 100, 100);
        step(1'b0, 32'h0, 100, 100);
        chk("two_in_flight", 32'(memq.size()), 32'd2);
        step(1'b1, 32'h0000_0103, 0, 100);
        hs_count = 0;
        repeat (12) step(1'b0, 32'h0, 100, 100);
        chk("redirect_stream_resumed", 32'(hs_count > 0), 32'd1);

        // Memory stall holds the request, then wrap past the top of memory
        lat_lo = 1; lat_hi = 1;
        repeat (4) step(1'b0, 32'h0, 100, 100);
        repeat (3) step(1'b0, 32'h0, 0, 100);
        repeat (4) step(1'b0, 32'h0, 100, 100);
        step(1'b1, 32'hFFFF_FFF4, 100, 100);
        repeat (12) step(1'b0, 32'h0, 100, 100);
        chk("wrap_seen", 32'(saw_wrap), 32'd1);

        // Randomized traffic against the reference model
        lat_lo = 1; lat_hi = 4;
        hs_count = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!prev_redir && $urandom_range(99) < 3)
                step(1'b1, $urandom, 70, 70);
            else
                step(1'b0, 32'h0, 70, 70);
        end
        chk("random_progress", 32'(hs_count > 200), 32'd1);

        // Asynchronous reset while discarding stale responses
        lat_lo = 4; lat_hi = 4;
        repeat (6) step(1'b0, 32'h0, 0, 100);
        step(1'b0, 32'h0, 100, 100);
        step(1'b0, 32'h0, 100, 100);
        step(1'b1, 32'h0000_2000, 0, 100);
        step(1'b0, 32'h0, 0, 100);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        drive_idle();
        #1;
        check_zero_outputs("async_reset");
        memq.delete();
        prev_redir = 1'b0;
        prev_stall = 1'b0;
        have_last_acc = 1'b0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        pc_exp   = 32'h0;
        req_exp  = 32'h0;
        last_due = cyc;
        @(posedge clk);
        #1;
        chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
        chk("restart_req_addr", imem_req_addr, 32'h0);
        lat_lo = 1; lat_hi = 1;
        hs_count = 0;
        repeat (20) step(1'b0, 32'h0, 100, 100);
        chk("restart_progress", 32'(hs_count >= 15), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
